// File: rtl/axi_burst_check_mst.sv
// AXI4 burst self-test master: writes one INCR burst of counting data, reads it
// back and counts the beats that do not match.
package axi_burst_check_pkg;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 128;
  localparam int unsigned IdWidth   = 6;
  localparam int unsigned UserWidth = 2;

  typedef struct packed {
    logic [IdWidth-1:0]     id;
    logic [AddrWidth-1:0]   addr;
    logic [7:0]             len;
    logic [2:0]             size;
    logic [1:0]             burst;
    logic                   lock;
    logic [3:0]             cache;
    logic [2:0]             prot;
    logic [3:0]             qos;
    logic [3:0]             region;
    logic [5:0]             atop;
    logic [UserWidth-1:0]   user;
  } aw_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
    logic [UserWidth-1:0]   user;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]     id;
    logic [1:0]             resp;
    logic [UserWidth-1:0]   user;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]     id;
    logic [AddrWidth-1:0]   addr;
    logic [7:0]             len;
    logic [2:0]             size;
    logic [1:0]             burst;
    logic                   lock;
    logic [3:0]             cache;
    logic [2:0]             prot;
    logic [3:0]             qos;
    logic [3:0]             region;
    logic [UserWidth-1:0]   user;
  } ar_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]     id;
    logic [DataWidth-1:0]   data;
    logic [1:0]             resp;
    logic                   last;
    logic [UserWidth-1:0]   user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    logic     b_valid;
    b_chan_t  b;
    logic     r_valid;
    r_chan_t  r;
  } axi_resp_t;
endpackage

module axi_burst_check_mst #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned IdWidth   = 6,
  parameter int unsigned UserWidth = 2,
  parameter type axi_req_t  = axi_burst_check_pkg::axi_req_t,
  parameter type axi_resp_t = axi_burst_check_pkg::axi_resp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [7:0]           len_i,
  input  logic [DataWidth-1:0] seed_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [8:0]           mism_cnt_o,
  output axi_req_t             axi_req_o,
  input  axi_resp_t            axi_rsp_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned SizeLog   = $clog2(StrbWidth);

  typedef enum logic [2:0] {IDLE, CHK4K, AW, W, B, AR, R, DONE} state_e;

  state_e               state_q;
  logic [AddrWidth-1:0] addr_q;
  logic [7:0]           len_q;
  logic [DataWidth-1:0] seed_q;
  logic [DataWidth-1:0] data_q;
  logic [8:0]           beat_q;
  logic                 aw_valid_q;
  logic                 w_valid_q;
  logic                 w_last_q;
  logic                 b_ready_q;
  logic                 ar_valid_q;
  logic                 r_ready_q;

  logic [AddrWidth-1:0] addr_aligned;
  logic [31:0]          end_off;
  logic                 crosses_4k;
  logic                 last_beat;
  logic                 r_fail;
  logic                 rsp_unused;

  // The 4KiB test works on the in-page offset; the sum can reach 8191, so 32 bits is ample.
  assign addr_aligned = addr_i & ~AddrWidth'(StrbWidth - 1);
  assign end_off      = 32'(addr_aligned[11:0]) + ((32'(len_i) + 32'd1) << SizeLog);
  assign crosses_4k   = end_off > 32'd4096;

  assign last_beat = (beat_q == {1'b0, len_q});
  assign r_fail    = (axi_rsp_i.r.data != data_q) || (axi_rsp_i.r.resp != 2'b00) ||
                     (axi_rsp_i.r.last != last_beat);

  assign rsp_unused = ^{axi_rsp_i.b.id, axi_rsp_i.b.user, axi_rsp_i.r.id, axi_rsp_i.r.user};

  always_comb begin
    axi_req_o             = '0;
    axi_req_o.aw.id       = {IdWidth{1'b0}};
    axi_req_o.aw.user     = {UserWidth{1'b0}};
    axi_req_o.aw.addr     = addr_q;
    axi_req_o.aw.len      = len_q;
    axi_req_o.aw.size     = aw_valid_q ? 3'(SizeLog) : 3'd0;
    axi_req_o.aw.burst    = aw_valid_q ? 2'b01 : 2'b00;
    axi_req_o.aw_valid    = aw_valid_q;
    axi_req_o.w.data      = data_q & {DataWidth{w_valid_q}};
    axi_req_o.w.strb      = {StrbWidth{w_valid_q}};
    axi_req_o.w.last      = w_last_q;
    axi_req_o.w_valid     = w_valid_q;
    axi_req_o.b_ready     = b_ready_q;
    axi_req_o.ar.addr     = addr_q;
    axi_req_o.ar.len      = len_q;
    axi_req_o.ar.size     = ar_valid_q ? 3'(SizeLog) : 3'd0;
    axi_req_o.ar.burst    = ar_valid_q ? 2'b01 : 2'b00;
    axi_req_o.ar_valid    = ar_valid_q;
    axi_req_o.r_ready     = r_ready_q;
  end

  // data_q doubles as the W payload and the expected R data; both follow seed+beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      seed_q     <= '0;
      data_q     <= '0;
      beat_q     <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      w_last_q   <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      error_o    <= 1'b0;
      mism_cnt_o <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            addr_q     <= addr_aligned;
            len_q      <= len_i;
            seed_q     <= seed_i;
            busy_o     <= 1'b1;
            error_o    <= 1'b0;
            mism_cnt_o <= '0;
            if (crosses_4k) begin
              state_q <= CHK4K;
            end else begin
              aw_valid_q <= 1'b1;
              state_q    <= AW;
            end
          end
        end
        CHK4K: begin
          error_o <= 1'b1;
          busy_o  <= 1'b0;
          done_o  <= 1'b1;
          state_q <= DONE;
        end
        AW: begin
          if (axi_rsp_i.aw_ready) begin
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b1;
            data_q     <= seed_q;
            beat_q     <= '0;
            w_last_q   <= (len_q == 8'd0);
            state_q    <= W;
          end
        end
        W: begin
          if (axi_rsp_i.w_ready) begin
            if (w_last_q) begin
              w_valid_q <= 1'b0;
              w_last_q  <= 1'b0;
              b_ready_q <= 1'b1;
              state_q   <= B;
            end else begin
              beat_q   <= beat_q + 9'd1;
              data_q   <= data_q + 1'b1;
              w_last_q <= ((beat_q + 9'd1) == {1'b0, len_q});
            end
          end
        end
        B: begin
          if (axi_rsp_i.b_valid) begin
            if (axi_rsp_i.b.resp != 2'b00) error_o <= 1'b1;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b1;
            state_q    <= AR;
          end
        end
        AR: begin
          if (axi_rsp_i.ar_ready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            beat_q     <= '0;
            data_q     <= seed_q;
            state_q    <= R;
          end
        end
        R: begin
          if (axi_rsp_i.r_valid) begin
            if (r_fail) begin
              error_o <= 1'b1;
              if (mism_cnt_o != 9'h1FF) mism_cnt_o <= mism_cnt_o + 9'd1;
            end
            // An early r_last or the final expected beat both close the read.
            if (axi_rsp_i.r.last || last_beat) begin
              r_ready_q <= 1'b0;
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
              state_q   <= DONE;
            end else begin
              beat_q <= beat_q + 9'd1;
              data_q <= data_q + 1'b1;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_check_mst.sv
// Directed bench for axi_burst_check_mst against a small behavioural AXI memory
// with optional backpressure and fault injection.
module tb_axi_burst_check_mst;
  import axi_burst_check_pkg::*;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic [63:0]   addr_i;
  logic [7:0]    len_i;
  logic [127:0]  seed_i;
  logic          busy_o;
  logic          done_o;
  logic          error_o;
  logic [8:0]    mism_cnt_o;
  axi_req_t      req;
  axi_resp_t     rsp;

  int checks = 0;
  int errors = 0;

  logic bp_mode = 1'b0;
  logic fault_mode = 1'b0;

  axi_burst_check_mst dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start_i),
    .addr_i     (addr_i),
    .len_i      (len_i),
    .seed_i     (seed_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .error_o    (error_o),
    .mism_cnt_o (mism_cnt_o),
    .axi_req_o  (req),
    .axi_rsp_i  (rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural slave memory: 256 words indexed by addr[11:4].
  logic [127:0] mem [256];
  logic [7:0]   w_idx, r_idx, r_len;
  logic [8:0]   r_cnt;
  logic         r_active, b_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp <= '0; w_idx <= '0; r_idx <= '0; r_len <= '0; r_cnt <= '0;
      r_active <= 1'b0; b_pend <= 1'b0;
    end else begin
      rsp.aw_ready <= bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      rsp.w_ready  <= bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      rsp.ar_ready <= bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (req.aw_valid && rsp.aw_ready) w_idx <= req.aw.addr[11:4];
      if (req.w_valid && rsp.w_ready) begin
        mem[w_idx] <= req.w.data;
        w_idx <= w_idx + 8'd1;
        if (req.w.last) b_pend <= 1'b1;
      end
      if (rsp.b_valid && req.b_ready) rsp.b_valid <= 1'b0;
      else if (b_pend && !rsp.b_valid && (!bp_mode || $urandom_range(0, 1) == 1)) begin
        rsp.b_valid <= 1'b1; rsp.b.resp <= 2'b00; b_pend <= 1'b0;
      end
      if (req.ar_valid && rsp.ar_ready) begin
        r_active <= 1'b1; r_idx <= req.ar.addr[11:4]; r_len <= req.ar.len; r_cnt <= '0;
      end
      if (!rsp.r_valid || req.r_ready) begin
        if (r_active && (!bp_mode || $urandom_range(0, 1) == 1)) begin
          rsp.r_valid <= 1'b1;
          rsp.r.data  <= mem[r_idx] ^ ((fault_mode && r_cnt == 9'd3) ? 128'd1 : 128'd0);
          rsp.r.resp  <= (fault_mode && r_cnt == 9'd5) ? 2'b10 : 2'b00;
          rsp.r.last  <= (r_cnt == {1'b0, r_len});
          r_idx <= r_idx + 8'd1;
          r_cnt <= r_cnt + 9'd1;
          if (r_cnt == {1'b0, r_len}) r_active <= 1'b0;
        end else begin
          rsp.r_valid <= 1'b0;
        end
      end
    end
  end

  // Per-operation observations gathered by run_op.
  int       op_done_cycle, last_r_cycle, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  int       wlast_cnt, wlast_beat, stab_viol;
  logic     aw_seen, ar_seen, busy_first, reset_hit;
  logic [127:0] last_w_data, last_r_data;
  aw_chan_t aw_cap, pa_aw;
  ar_chan_t ar_cap, pa_ar;
  w_chan_t  pa_w;
  logic     pv_aw, pr_aw, pv_w, pr_w, pv_ar, pr_ar;

  task automatic run_op(input logic [63:0] a, input logic [7:0] l, input logic [127:0] s,
                        input int pulse_at, input int reset_at_w, input int budget);
    int cyc;
    op_done_cycle = -1; last_r_cycle = -1; aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    wlast_cnt = 0; wlast_beat = -1; stab_viol = 0; aw_seen = 0; ar_seen = 0; reset_hit = 0;
    last_w_data = '0; last_r_data = '0; aw_cap = '0; ar_cap = '0;
    pv_aw = 0; pv_w = 0; pv_ar = 0; pr_aw = 0; pr_w = 0; pr_ar = 0;
    @(negedge clk);
    start_i = 1'b1; addr_i = a; len_i = l; seed_i = s;
    @(negedge clk);
    start_i = 1'b0;
    busy_first = busy_o;
    cyc = 0;
    while (cyc < budget && op_done_cycle < 0) begin
      if (cyc == pulse_at) begin
        start_i = 1'b1; addr_i = 64'hFF0; len_i = 8'd1; seed_i = '0;
      end else begin
        start_i = 1'b0;
      end
      if (reset_at_w >= 0 && req.w_valid && w_hs == reset_at_w) begin
        rst_n = 1'b0; reset_hit = 1'b1;
        break;
      end
      if (req.aw_valid) aw_seen = 1'b1;
      if (req.ar_valid) ar_seen = 1'b1;
      if (pv_aw && !pr_aw && (!req.aw_valid || req.aw !== pa_aw)) stab_viol++;
      if (pv_w  && !pr_w  && (!req.w_valid  || req.w  !== pa_w))  stab_viol++;
      if (pv_ar && !pr_ar && (!req.ar_valid || req.ar !== pa_ar)) stab_viol++;
      pv_aw = req.aw_valid; pr_aw = rsp.aw_ready; pa_aw = req.aw;
      pv_w  = req.w_valid;  pr_w  = rsp.w_ready;  pa_w  = req.w;
      pv_ar = req.ar_valid; pr_ar = rsp.ar_ready; pa_ar = req.ar;
      if (req.aw_valid && rsp.aw_ready) begin aw_hs++; aw_cap = req.aw; end
      if (req.w_valid && rsp.w_ready) begin
        if (req.w.last) begin wlast_cnt++; wlast_beat = w_hs; end
        last_w_data = req.w.data;
        w_hs++;
      end
      if (rsp.b_valid && req.b_ready) b_hs++;
      if (req.ar_valid && rsp.ar_ready) begin ar_hs++; ar_cap = req.ar; end
      if (rsp.r_valid && req.r_ready) begin r_hs++; last_r_data = rsp.r.data; last_r_cycle = cyc; end
      if (done_o) op_done_cycle = cyc;
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; addr_i = '0; len_i = '0; seed_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready, busy_o, done_o, error_o} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000000",
               {req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready, busy_o, done_o, error_o});
    end
    checks++;
    if (mism_cnt_o !== 9'd0) begin errors++; $display("[TB] FAIL reset_mism: got %0d expected 0", mism_cnt_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    run_op(64'h1000, 8'd0, 128'hA5, -1, -1, 2000);
    checks++;
    if (op_done_cycle < 0) begin errors++; $display("[TB] FAIL single_done: got timeout expected done_o"); end
    checks++;
    if (busy_first !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b expected 1", busy_first); end
    checks++;
    if ({aw_hs, w_hs, b_hs, ar_hs, r_hs} !== {32'd1, 32'd1, 32'd1, 32'd1, 32'd1}) begin
      errors++;
      $display("[TB] FAIL single_hs: got aw%0d w%0d b%0d ar%0d r%0d expected 1 each", aw_hs, w_hs, b_hs, ar_hs, r_hs);
    end
    checks++;
    if ({aw_cap.addr, aw_cap.len, aw_cap.size, aw_cap.burst, aw_cap.id} !== {64'h1000, 8'd0, 3'd4, 2'b01, 6'd0}) begin
      errors++;
      $display("[TB] FAIL single_aw: got addr %h len %0d size %0d burst %0d expected 1000/0/4/1",
               aw_cap.addr, aw_cap.len, aw_cap.size, aw_cap.burst);
    end
    checks++;
    if ({ar_cap.addr, ar_cap.len, ar_cap.size, ar_cap.burst} !== {64'h1000, 8'd0, 3'd4, 2'b01}) begin
      errors++;
      $display("[TB] FAIL single_ar: got addr %h len %0d size %0d burst %0d expected 1000/0/4/1",
               ar_cap.addr, ar_cap.len, ar_cap.size, ar_cap.burst);
    end
    checks++;
    if (last_w_data !== 128'hA5 || wlast_beat !== 0) begin
      errors++; $display("[TB] FAIL single_w: got data %h last@%0d expected a5 last@0", last_w_data, wlast_beat);
    end
    checks++;
    if (last_r_data !== 128'hA5) begin errors++; $display("[TB] FAIL single_r: got %h expected a5", last_r_data); end
    checks++;
    if (op_done_cycle !== last_r_cycle + 1) begin
      errors++; $display("[TB] FAIL single_done_lat: got cycle %0d expected %0d", op_done_cycle, last_r_cycle + 1);
    end
    checks++;
    if ({error_o, mism_cnt_o} !== 10'd0) begin
      errors++; $display("[TB] FAIL single_status: got err %b mism %0d expected 0/0", error_o, mism_cnt_o);
    end
    checks++;
    if ({done_o, busy_o} !== 2'b00) begin
      errors++; $display("[TB] FAIL single_pulse: got done %b busy %b expected 0/0", done_o, busy_o);
    end
  endtask

  task automatic test_full_page(input string tag);
    run_op(64'h0, 8'd255, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF0, -1, -1, 20000);
    checks++;
    if (op_done_cycle < 0) begin errors++; $display("[TB] FAIL %s_done: got timeout expected done_o", tag); end
    checks++;
    if (w_hs !== 256 || wlast_cnt !== 1 || wlast_beat !== 255) begin
      errors++;
      $display("[TB] FAIL %s_wlast: got beats %0d lasts %0d last@%0d expected 256/1/255", tag, w_hs, wlast_cnt, wlast_beat);
    end
    checks++;
    if (last_w_data !== 128'hEF) begin errors++; $display("[TB] FAIL %s_wdata: got %h expected ef", tag, last_w_data); end
    checks++;
    if (r_hs !== 256 || last_r_data !== 128'hEF) begin
      errors++; $display("[TB] FAIL %s_rdata: got %0d beats last %h expected 256 beats last ef", tag, r_hs, last_r_data);
    end
    checks++;
    if ({error_o, mism_cnt_o} !== 10'd0) begin
      errors++; $display("[TB] FAIL %s_status: got err %b mism %0d expected 0/0", tag, error_o, mism_cnt_o);
    end
  endtask

  task automatic test_4k_cross();
    run_op(64'hFF0, 8'd1, 128'h1, -1, -1, 50);
    checks++;
    if (op_done_cycle !== 1) begin errors++; $display("[TB] FAIL cross_done_lat: got cycle %0d expected 1", op_done_cycle); end
    checks++;
    if ({aw_seen, ar_seen} !== 2'b00) begin
      errors++; $display("[TB] FAIL cross_no_traffic: got aw %b ar %b expected 0/0", aw_seen, ar_seen);
    end
    checks++;
    if ({error_o, mism_cnt_o} !== {1'b1, 9'd0}) begin
      errors++; $display("[TB] FAIL cross_status: got err %b mism %0d expected 1/0", error_o, mism_cnt_o);
    end
  endtask

  task automatic test_backpressure();
    bp_mode = 1'b1;
    test_full_page("bp");
    checks++;
    if (stab_viol !== 0) begin errors++; $display("[TB] FAIL bp_stable: got %0d violations expected 0", stab_viol); end
    bp_mode = 1'b0;
  endtask

  task automatic test_fault();
    fault_mode = 1'b1;
    run_op(64'h2000, 8'd7, 128'h1234, -1, -1, 2000);
    fault_mode = 1'b0;
    checks++;
    if (op_done_cycle < 0 || r_hs !== 8) begin
      errors++; $display("[TB] FAIL fault_done: got done@%0d beats %0d expected done and 8 beats", op_done_cycle, r_hs);
    end
    checks++;
    if ({error_o, mism_cnt_o} !== {1'b1, 9'd2}) begin
      errors++; $display("[TB] FAIL fault_status: got err %b mism %0d expected 1/2", error_o, mism_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    run_op(64'h3009, 8'd7, 128'h77, 3, -1, 2000);
    checks++;
    if (aw_hs !== 1 || aw_cap.addr !== 64'h3000) begin
      errors++; $display("[TB] FAIL busy_ignore_aw: got %0d AW addr %h expected 1 AW addr 3000", aw_hs, aw_cap.addr);
    end
    checks++;
    if (op_done_cycle < 0 || last_r_data !== 128'h7E || {error_o, mism_cnt_o} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL busy_ignore_status: got done@%0d r %h err %b mism %0d expected done r 7e 0/0",
               op_done_cycle, last_r_data, error_o, mism_cnt_o);
    end
    run_op(64'h4000, 8'd7, 128'h55, -1, 2, 2000);
    checks++;
    if (reset_hit !== 1'b1) begin errors++; $display("[TB] FAIL midreset_reach: got no W beat 2 expected reset applied"); end
    @(posedge clk);
    #1;
    checks++;
    if ({req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready, busy_o, done_o, error_o, mism_cnt_o} !== 17'd0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got %b expected all 0",
               {req.aw_valid, req.w_valid, req.ar_valid, req.b_ready, req.r_ready, busy_o, done_o, error_o, mism_cnt_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(64'h5000, 8'd3, 128'h99, -1, -1, 2000);
    checks++;
    if (op_done_cycle < 0 || r_hs !== 4 || last_r_data !== 128'h9C) begin
      errors++; $display("[TB] FAIL after_reset_op: got done@%0d beats %0d last %h expected done 4 beats 9c",
                         op_done_cycle, r_hs, last_r_data);
    end
    checks++;
    if ({error_o, mism_cnt_o} !== 10'd0) begin
      errors++; $display("[TB] FAIL after_reset_status: got err %b mism %0d expected 0/0", error_o, mism_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_page("page");
    test_4k_cross();
    test_backpressure();
    test_fault();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
